// File: rtl/video_pkg.sv
// Shared video-domain definitions: pixel/coordinate widths used by the
// downscaler and its readers, and the window reader FSM state encoding.
package video_pkg;

    localparam int PIX_W   = 16;   // RGB565
    localparam int COORD_W = 12;   // raster / window coordinates

    // Window reader FSM states
    localparam logic [1:0] ST_IDLE   = 2'd0;  // after reset, waiting for first frame start
    localparam logic [1:0] ST_ARMED  = 2'd1;  // frame started, waiting for the window top line
    localparam logic [1:0] ST_ACTIVE = 2'd2;  // window lines being read
    localparam logic [1:0] ST_DONE   = 2'd3;  // window finished for this frame

endpackage

// File: rtl/video_timing_delay.sv
// N-stage register pipe for the {vs, hs, de} timing triple, used to keep the
// sync/enable outputs aligned with the pixel data path.
module video_timing_delay #(
    parameter int N = 3
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_vs,
    input  logic i_hs,
    input  logic i_de,
    output logic o_vs,
    output logic o_hs,
    output logic o_de
);

    logic [2:0] r_pipe [N];

    // Shift the timing triple one stage per clock; reset clears every stage.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < N; i++) r_pipe[i] <= 3'b000;
        end else begin
            r_pipe[0] <= {i_vs, i_hs, i_de};
            for (int i = 1; i < N; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign {o_vs, o_hs, o_de} = r_pipe[N-1];

endmodule

// File: rtl/downscale_window_reader.sv
// Video-domain reader for the 3x downscaler: tracks the raster, places the
// OUT_W x OUT_H image at (WIN_X0, WIN_Y0), reads it through the downscaler read
// port and emits a timing-aligned RGB565 stream with BG_COLOR elsewhere.
//
// Read port: rd_en is a one-cycle strobe with rd_x/rd_y valid in the same
// cycle; the downscaler has no back-pressure and returns rd_data exactly one
// cycle after each strobe. rd_x/rd_y hold their last value while rd_en is low.
module downscale_window_reader
    import video_pkg::*;
#(
    parameter int           OUT_W    = 426,
    parameter int           OUT_H    = 240,
    parameter logic [11:0]  WIN_X0   = 12'd0,
    parameter logic [11:0]  WIN_Y0   = 12'd0,
    parameter logic [15:0]  BG_COLOR = 16'h0000,
    parameter logic         VS_POL   = 1'b1
) (
    input  logic               rd_clk,
    input  logic               rd_rst,
    input  logic               vid_vs,
    input  logic               vid_hs,
    input  logic               vid_de,
    output logic               rd_en,
    output logic [COORD_W-1:0] rd_x,
    output logic [COORD_W-1:0] rd_y,
    output logic               rd_busy,
    output logic               rd_vs,
    input  logic [PIX_W-1:0]   rd_data,
    output logic               out_vs,
    output logic               out_hs,
    output logic               out_de,
    output logic [PIX_W-1:0]   out_data
);

    localparam logic [12:0] X_LO   = {1'b0, WIN_X0};
    localparam logic [12:0] Y_LO   = {1'b0, WIN_Y0};
    localparam logic [12:0] Y_LAST = Y_LO + 13'(OUT_H) - 13'd1;
    localparam logic [11:0] CNT_MAX = 12'hFFF;

    logic               r_vs_q;
    logic               r_de_q;
    logic [11:0]        r_px;
    logic [11:0]        r_ln;
    logic [1:0]         r_state;
    logic               r_busy;
    logic               r_rd_en;
    logic [11:0]        r_rd_x;
    logic [11:0]        r_rd_y;
    logic               r_en_d;
    logic [PIX_W-1:0]   r_out_data;

    logic               w_fs;
    logic               w_de_rise;
    logic               w_de_fall;
    logic [11:0]        w_px;
    logic [12:0]        w_dx;
    logic [12:0]        w_dy;
    logic               w_in_win;
    logic               w_issue;
    logic [1:0]         w_state_nxt;

    assign w_fs      = (vid_vs == VS_POL) && (r_vs_q != VS_POL);
    assign w_de_rise = vid_de && !r_de_q;
    assign w_de_fall = !vid_de && r_de_q;

    // px is 0 in the de-rise cycle itself, so the register holds the count
    // for the following cycle.
    assign w_px = w_de_rise ? 12'd0 : r_px;

    // Offsets are taken in 13 bits: a coordinate left of / above the window
    // wraps to >= 4097, which can never be below OUT_W/OUT_H, and a window
    // running past 4095 cannot alias back onto low coordinates.
    assign w_dx     = {1'b0, w_px} - X_LO;
    assign w_dy     = {1'b0, r_ln} - Y_LO;
    assign w_in_win = vid_de && (w_dx < 13'(OUT_W)) && (w_dy < 13'(OUT_H));
    assign w_issue  = w_in_win && (r_state != ST_IDLE);

    // Sync edge detection and saturating pixel/line counters.
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            r_vs_q <= 1'b0;
            r_de_q <= 1'b0;
            r_px   <= 12'd0;
            r_ln   <= 12'd0;
        end else begin
            r_vs_q <= vid_vs;
            r_de_q <= vid_de;
            if (vid_de) r_px <= (w_px == CNT_MAX) ? w_px : w_px + 12'd1;
            if (w_fs)
                r_ln <= 12'd0;
            else if (w_de_fall && r_ln != CNT_MAX)
                r_ln <= r_ln + 12'd1;
        end
    end

    // Next-state: any frame start resynchronises to ARMED; a window clipped
    // by the raster bottom stays ACTIVE until that frame start.
    always_comb begin
        w_state_nxt = r_state;
        if (w_fs) begin
            w_state_nxt = ST_ARMED;
        end else begin
            case (r_state)
                ST_ARMED:  if (w_de_rise && r_ln == WIN_Y0) w_state_nxt = ST_ACTIVE;
                ST_ACTIVE: if (w_de_fall && ({1'b0, r_ln} == Y_LAST || r_ln == CNT_MAX))
                               w_state_nxt = ST_DONE;
                default:   w_state_nxt = r_state;
            endcase
        end
    end

    // FSM state and registered busy flag.
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == ST_ACTIVE);
        end
    end

    // Issue stage: strobe the downscaler for every in-window pixel once a
    // frame start has been seen.
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            r_rd_en <= 1'b0;
            r_rd_x  <= 12'd0;
            r_rd_y  <= 12'd0;
        end else begin
            r_rd_en <= w_issue;
            if (w_issue) begin
                r_rd_x <= w_dx[11:0];
                r_rd_y <= w_dy[11:0];
            end
        end
    end

    // Capture stage: take rd_data one cycle after the strobe, else background.
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            r_en_d     <= 1'b0;
            r_out_data <= BG_COLOR;
        end else begin
            r_en_d     <= r_rd_en;
            r_out_data <= r_en_d ? rd_data : BG_COLOR;
        end
    end

    video_timing_delay #(
        .N (3)
    ) u_timing_delay (
        .i_clk (rd_clk),
        .i_rst (rd_rst),
        .i_vs  (vid_vs),
        .i_hs  (vid_hs),
        .i_de  (vid_de),
        .o_vs  (out_vs),
        .o_hs  (out_hs),
        .o_de  (out_de)
    );

    assign rd_en    = r_rd_en;
    assign rd_x     = r_rd_x;
    assign rd_y     = r_rd_y;
    assign rd_busy  = r_busy;
    assign rd_vs    = r_vs_q;
    assign out_data = r_out_data;

endmodule

// File: tb/tb_downscale_window_reader.sv
// Bench for downscale_window_reader on a small 40x20 raster: DUT A has an
// 8x5 window at (4,3), DUT B an 8x5 window at (36,17) clipped by the raster.
module tb_downscale_window_reader;

  localparam int H_ACT = 40;
  localparam int H_BLK = 8;
  localparam int V_ACT = 20;
  localparam int V_BLK = 4;
  localparam logic [15:0] BG = 16'h1234;
  localparam int WXA = 4,  WYA = 3,  OWA = 8, OHA = 5;
  localparam int WXB = 36, WYB = 17, OWB = 8, OHB = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rd_rst = 1'b1;
  logic vid_vs = 1'b0, vid_hs = 1'b0, vid_de = 1'b0;

  logic rd_en_a, rd_busy_a, rd_vs_a, out_vs_a, out_hs_a, out_de_a;
  logic [11:0] rd_x_a, rd_y_a;
  logic [15:0] rd_data_a = 16'h0, out_data_a;
  logic rd_en_b, rd_busy_b, rd_vs_b, out_vs_b, out_hs_b, out_de_b;
  logic [11:0] rd_x_b, rd_y_b;
  logic [15:0] rd_data_b = 16'h0, out_data_b;

  downscale_window_reader #(
    .OUT_W(OWA), .OUT_H(OHA), .WIN_X0(12'(WXA)), .WIN_Y0(12'(WYA)),
    .BG_COLOR(BG), .VS_POL(1'b1)
  ) dut_a (
    .rd_clk(clk), .rd_rst(rd_rst), .vid_vs(vid_vs), .vid_hs(vid_hs), .vid_de(vid_de),
    .rd_en(rd_en_a), .rd_x(rd_x_a), .rd_y(rd_y_a), .rd_busy(rd_busy_a), .rd_vs(rd_vs_a),
    .rd_data(rd_data_a), .out_vs(out_vs_a), .out_hs(out_hs_a), .out_de(out_de_a),
    .out_data(out_data_a)
  );

  downscale_window_reader #(
    .OUT_W(OWB), .OUT_H(OHB), .WIN_X0(12'(WXB)), .WIN_Y0(12'(WYB)),
    .BG_COLOR(BG), .VS_POL(1'b1)
  ) dut_b (
    .rd_clk(clk), .rd_rst(rd_rst), .vid_vs(vid_vs), .vid_hs(vid_hs), .vid_de(vid_de),
    .rd_en(rd_en_b), .rd_x(rd_x_b), .rd_y(rd_y_b), .rd_busy(rd_busy_b), .rd_vs(rd_vs_b),
    .rd_data(rd_data_b), .out_vs(out_vs_b), .out_hs(out_hs_b), .out_de(out_de_b),
    .out_data(out_data_b)
  );

  // Downscaler read-port models: pixel value = rd_y*OUT_W + rd_x, 1-cycle latency.
  always @(posedge clk) begin
    if (rd_en_a) rd_data_a <= 16'(32'(rd_y_a) * OWA + 32'(rd_x_a));
    if (rd_en_b) rd_data_b <= 16'(32'(rd_y_b) * OWB + 32'(rd_x_b));
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  // {en_a, x_a[12], y_a[12], busy_a, en_b, x_b[12], y_b[12], rd_vs}
  logic [51:0] exp_rd_q[$];
  // {vs, hs, de, data_a[16], data_b[16]}
  logic [34:0] exp_out_q[$];

  logic g_rst = 1'b0, g_valid = 1'b0, m_vs = 1'b0, m_de = 1'b0, m_busy = 1'b0;
  int cnt_a = 0, cnt_b = 0;
  int line_cnt_a[8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic in_win(input int x, input int y, input int wx, input int wy,
                                  input int ow, input int oh);
    return (x >= wx) && (x < wx + ow) && (y >= wy) && (y < wy + oh);
  endfunction

  // ---------------- driver tasks ----------------
  // One pixel clock: drive inputs (sampled at the next edge) and queue the
  // outputs expected after that edge (rd side) and two edges later (out side).
  task automatic cyc(input logic vs, input logic hs, input logic de, input int x, input int y);
    logic fs, ea, eb;
    logic [15:0] da, db;
    @(posedge clk);
    #1;
    rd_rst = g_rst; vid_vs = vs; vid_hs = hs; vid_de = de;
    fs = vs && !m_vs;
    ea = !g_rst && g_valid && de && in_win(x, y, WXA, WYA, OWA, OHA);
    eb = !g_rst && g_valid && de && in_win(x, y, WXB, WYB, OWB, OHB);
    da = ea ? 16'((y - WYA) * OWA + (x - WXA)) : BG;
    db = eb ? 16'((y - WYB) * OWB + (x - WXB)) : BG;
    if (g_rst || fs) m_busy = 1'b0;
    else if (g_valid && de && !m_de && y == WYA) m_busy = 1'b1;
    else if (!de && m_de && y == WYA + OHA - 1) m_busy = 1'b0;
    exp_rd_q.push_back({ea, 12'(x - WXA), 12'(y - WYA), m_busy,
                        eb, 12'(x - WXB), 12'(y - WYB), vs && !g_rst});
    if (g_rst) begin
      exp_out_q.delete();
      repeat (3) exp_out_q.push_back({3'b000, BG, BG});
    end else begin
      exp_out_q.push_back({vs, hs, de, da, db});
    end
    m_vs = g_rst ? 1'b0 : vs;
    m_de = g_rst ? 1'b0 : de;
    if (g_rst) g_valid = 1'b0;
    else if (fs) g_valid = 1'b1;
  endtask

  // One raster line: active pixels, then hblank with hs on its first 4 cycles.
  // vs_blank raises vs mid-line; rst_x pulses reset at that active column.
  task automatic line(input int y, input logic vs_blank, input int rst_x);
    for (int x = 0; x < H_ACT; x++) begin
      g_rst = (x == rst_x);
      cyc(1'b0, 1'b0, 1'b1, x, y);
    end
    g_rst = 1'b0;
    for (int b = 0; b < H_BLK; b++)
      cyc(vs_blank && (b == 4 || b == 5), b < 4, 1'b0, H_ACT + b, y);
  endtask

  task automatic vblank();
    for (int l = 0; l < V_BLK; l++)
      for (int c = 0; c < H_ACT + H_BLK; c++)
        cyc(l < 2, (c >= H_ACT) && (c < H_ACT + 4), 1'b0, c, V_ACT + l);
  endtask

  task automatic full_frame();
    for (int y = 0; y < V_ACT; y++) line(y, 1'b0, -1);
    vblank();
  endtask

  task automatic clr_counts();
    cnt_a = 0;
    cnt_b = 0;
    for (int i = 0; i < 8; i++) line_cnt_a[i] = 0;
  endtask

  task automatic check_counts(input string tag, input int exp_a, input int exp_b);
    check({tag, "_rd_en_a"}, 32'(cnt_a), 32'(exp_a));
    check({tag, "_rd_en_b"}, 32'(cnt_b), 32'(exp_b));
  endtask

  task automatic check_lines(input string tag);
    for (int i = 0; i < OHA; i++)
      check($sformatf("%s_line%0d", tag, i), 32'(line_cnt_a[i]), 32'(OWA));
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin : mon
    logic [51:0] er;
    logic [34:0] eo;
    if (exp_rd_q.size() >= 2) begin
      er = exp_rd_q.pop_front();
      check("rd_en_a", 32'(rd_en_a), 32'(er[51]));
      if (er[51]) begin
        check("rd_x_a", 32'(rd_x_a), 32'(er[50:39]));
        check("rd_y_a", 32'(rd_y_a), 32'(er[38:27]));
      end
      check("rd_busy_a", 32'(rd_busy_a), 32'(er[26]));
      check("rd_en_b", 32'(rd_en_b), 32'(er[25]));
      if (er[25]) begin
        check("rd_x_b", 32'(rd_x_b), 32'(er[24:13]));
        check("rd_y_b", 32'(rd_y_b), 32'(er[12:1]));
      end
      check("rd_vs", 32'({rd_vs_a, rd_vs_b}), 32'({2{er[0]}}));
    end
    if (exp_out_q.size() >= 4) begin
      eo = exp_out_q.pop_front();
      check("out_timing_a", 32'({out_vs_a, out_hs_a, out_de_a}), 32'(eo[34:32]));
      check("out_timing_b", 32'({out_vs_b, out_hs_b, out_de_b}), 32'(eo[34:32]));
      check("out_data_a", 32'(out_data_a), 32'(eo[31:16]));
      check("out_data_b", 32'(out_data_b), 32'(eo[15:0]));
    end
    if (rd_en_a) begin
      cnt_a++;
      if (rd_y_a < 12'd8) line_cnt_a[rd_y_a]++;
    end
    if (rd_en_b) cnt_b++;
  end

  // ---------------- sequence ----------------
  initial begin
    clr_counts();
    rd_rst = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_rd_en", 32'({rd_en_a, rd_en_b}), 32'd0);
    check("rst_rd_busy", 32'({rd_busy_a, rd_busy_b}), 32'd0);
    check("rst_rd_vs", 32'({rd_vs_a, rd_vs_b}), 32'd0);
    check("rst_rd_xy", 32'({rd_x_a, rd_y_a}), 32'd0);
    check("rst_out_sync", 32'({out_vs_a, out_hs_a, out_de_a, out_vs_b, out_hs_b, out_de_b}), 32'd0);
    check("rst_out_data_a", 32'(out_data_a), 32'(BG));
    check("rst_out_data_b", 32'(out_data_b), 32'(BG));

    // Partial frame after reset: nothing may be read or shown.
    for (int y = 2; y < V_ACT; y++) line(y, 1'b0, -1);
    vblank();
    check_counts("partial", 0, 0);

    // First complete frame.
    clr_counts();
    full_frame();
    check_counts("frame1", OWA * OHA, 4 * 3);
    check_lines("frame1");

    // vs asserted in the hblank of window line 5: window is cut short.
    clr_counts();
    for (int y = 0; y < 5; y++) line(y, 1'b0, -1);
    line(5, 1'b1, -1);
    check_counts("resync_cut", 3 * OWA, 0);

    // Lines restart from 0; the window must start again at rd_y=0.
    clr_counts();
    full_frame();
    check_counts("resync_frame", OWA * OHA, 4 * 3);
    check_lines("resync_frame");

    // One-cycle reset in the middle of window line 5 (column 6).
    clr_counts();
    for (int y = 0; y < 5; y++) line(y, 1'b0, -1);
    line(5, 1'b0, 6);
    for (int y = 6; y < V_ACT; y++) line(y, 1'b0, -1);
    vblank();
    check_counts("midrst", 2 * OWA + 2, 0);

    // Recovery after the next frame start.
    clr_counts();
    full_frame();
    check_counts("recover", OWA * OHA, 4 * 3);
    check_lines("recover");

    repeat (4) cyc(1'b0, 1'b0, 1'b0, 0, V_ACT);
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
